cam_capture_ctrl: RTL
=====================

# cam_capture_ctrl

Frame-capture sequencer between `cam_read` and the dual-port frame buffer, clocked in the camera pixel-clock domain. It arms on a software command, aligns capture to the next VSYNC rising edge and forwards per-pixel write strobes to the RAM only while a frame is being captured. It generates the RAM address from its own counter and reports frame completion, short frames and a running frame count. It supports single-shot and continuous modes.

## Interface
- `AW`, 15: RAM address width.
- `FRAME_PIXELS`, 19200: pixels per frame; must be ≤ 2^AW.
- `FCW`, 8: frame counter width.

- `CAM_pclk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `CAM_vsync` in 1: camera VSYNC, already synchronous to `CAM_pclk`.
- `start` in 1: one-cycle command pulse that arms a capture.
- `stop` in 1: one-cycle command pulse that aborts arming or capture.
- `cont` in 1: continuous-mode level, sampled at frame end.
- `px_data_in` in 8: RGB332 pixel from `cam_read`.
- `px_wr_in` in 1: pixel-valid strobe from `cam_read`. Each high cycle is one pixel.
- `DP_RAM_addr_out` out AW: frame-buffer write address.
- `DP_RAM_data_out` out 8: frame-buffer write data.
- `DP_RAM_regW_out` out 1: frame-buffer write enable.
- `busy` out 1: high in ARM, CAPTURE and DONE.
- `frame_done` out 1: one-cycle pulse when a frame ends.
- `done` out 1: sticky; set with `frame_done`, cleared by an accepted `start`.
- `short_frame` out 1: sticky error; cleared by an accepted `start`.
- `frame_cnt` out FCW: number of complete frames, wraps.

## Operation
- `vs_rise = CAM_vsync & ~vs_d`, where `vs_d` is `CAM_vsync` registered. `vs_d` resets to 1, so a VSYNC that is already high at reset release produces no edge.
- `pix_cnt` is an AW-bit internal counter.
- States:
  - IDLE. An accepted `start` (with `stop` low) goes to ARM and clears `done`, `short_frame` and `pix_cnt`. `start` in any other state is ignored.
  - ARM. `vs_rise` goes to CAPTURE with `pix_cnt=0`. `px_wr_in` is dropped.
  - CAPTURE. When `px_wr_in=1`: issue a RAM write with addr=`pix_cnt` and data=`px_data_in`, then `pix_cnt++`.
    - If this write is pixel `FRAME_PIXELS-1`: go to DONE as a complete frame.
    - Else if `vs_rise` occurs: go to DONE as a short frame.
    - If the final write and `vs_rise` occur in the same cycle, the frame counts as complete.
  - DONE (one cycle). `frame_done=1` and `done` is set.
    - Complete frame: `frame_cnt++` (mod 2^FCW).
    - Short frame: `short_frame` is set and `frame_cnt` is unchanged.
    - Next state is ARM if `cont=1`, else IDLE. `pix_cnt` clears.
- `stop` in ARM or CAPTURE goes to IDLE on the next edge, with no `frame_done` and no counter change. `stop` wins over every other event in the same cycle, including the final pixel.
- `stop` in DONE does not suppress the DONE effects; the next state is forced to IDLE.
- No RAM writes are issued outside CAPTURE. `pix_cnt` never reaches `FRAME_PIXELS` on the address bus.

## Timing
- All outputs are registered.
- Reset values: state IDLE; all outputs 0; `frame_cnt=0`; `pix_cnt=0`.
- `start` high at edge N: `busy=1` from N+1.
- `CAM_vsync` first sampled high at edge K while in ARM: CAPTURE from K+1. A `px_wr_in` at edge K is dropped.
- `px_wr_in` at edge J in CAPTURE: `DP_RAM_regW_out=1` with the matching addr and data during J+1 to J+2. Latency is 1 cycle; `DP_RAM_regW_out` is low otherwise.
- Final pixel or `vs_rise` at edge E: DONE at E+1, so `frame_done` is high for exactly that one cycle.
  - Continuous mode: ARM at E+2; a `vs_rise` at E+2 or later starts the next frame.
  - A VSYNC rising edge that falls inside the DONE cycle is missed, and capture waits for the following frame.
- `stop` at edge S: IDLE and `busy=0` at S+1. A write accepted at S still appears at S+1.
- `rst` mid-capture: everything returns to reset values on the next edge; the in-flight write is discarded.

## Test plan
- Reset with `CAM_vsync=1` held, then release: no `vs_rise`, state IDLE, all outputs 0, `frame_cnt=0`.
- `start`, then VSYNC pulse, then 19200 `px_wr_in` strobes: addresses 0..19199 written in order, one `frame_done` pulse, `done=1`, `frame_cnt=1`, `busy=0`, `short_frame=0`.
- `start`, then VSYNC, then 100 strobes, then VSYNC: 100 writes at addresses 0..99, `short_frame=1`, `frame_cnt=0`, `done=1`. A following `start` clears `short_frame` and `done`.
- `cont=1`, with `FRAME_PIXELS=16` overridden, over 3 VSYNC-delimited frames of 16 strobes: 3 `frame_done` pulses, `frame_cnt=3`, addresses restart at 0 each frame, and strobes between frames are dropped.
- `start`, then strobes before VSYNC (dropped), then VSYNC, then 50 strobes, then `stop`: exactly 50 writes, no `frame_done`, `frame_cnt` unchanged, `busy=0` one cycle after `stop`.
- Final strobe coincident with VSYNC rise: complete frame, `short_frame=0`. A `stop` on the final strobe's edge gives no `frame_done`.

Source files
------------

// File: rtl/cam_capture_ctrl.sv
// Frame-capture sequencer between cam_read and the frame buffer.
// Arms on start, aligns to VSYNC, writes one frame, reports status.
module cam_capture_ctrl #(
  parameter int AW           = 15,
  parameter int FRAME_PIXELS = 19200,
  parameter int FCW          = 8
) (
  input  logic          CAM_pclk,
  input  logic          rst,
  input  logic          CAM_vsync,
  input  logic          start,
  input  logic          stop,
  input  logic          cont,
  input  logic [7:0]    px_data_in,
  input  logic          px_wr_in,
  output logic [AW-1:0] DP_RAM_addr_out,
  output logic [7:0]    DP_RAM_data_out,
  output logic          DP_RAM_regW_out,
  output logic          busy,
  output logic          frame_done,
  output logic          done,
  output logic          short_frame,
  output logic [FCW-1:0] frame_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_CAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [AW-1:0] LAST_PIX = AW'(FRAME_PIXELS - 1);

  logic [1:0]     state_q, state_d;
  logic           vs_d_q;
  logic [AW-1:0]  pix_cnt_q, pix_cnt_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [7:0]     data_q, data_d;
  logic           wr_q, wr_d;
  logic           busy_q, busy_d;
  logic           fdone_q, fdone_d;
  logic           done_q, done_d;
  logic           short_q, short_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           vs_rise;

  assign vs_rise = CAM_vsync & ~vs_d_q;

  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wr_d      = 1'b0;
    fdone_d   = 1'b0;
    done_d    = done_q;
    short_d   = short_q;
    fcnt_d    = fcnt_q;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d   = S_ARM;
          done_d    = 1'b0;
          short_d   = 1'b0;
          pix_cnt_d = '0;
        end
      end
      S_ARM: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (vs_rise) begin
          state_d   = S_CAP;
          pix_cnt_d = '0;
        end
      end
      S_CAP: begin
        // the write goes out even when stop aborts the frame
        if (px_wr_in) begin
          wr_d      = 1'b1;
          addr_d    = pix_cnt_q;
          data_d    = px_data_in;
          pix_cnt_d = pix_cnt_q + AW'(1);
        end
        if (stop) begin
          state_d = S_IDLE;
        end else if (px_wr_in && pix_cnt_q == LAST_PIX) begin
          state_d = S_DONE;
          fdone_d = 1'b1;
          done_d  = 1'b1;
          fcnt_d  = fcnt_q + FCW'(1);
        end else if (vs_rise) begin
          state_d = S_DONE;
          fdone_d = 1'b1;
          done_d  = 1'b1;
          short_d = 1'b1;
        end
      end
      default: begin
        state_d   = (cont && !stop) ? S_ARM : S_IDLE;
        pix_cnt_d = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CAM_pclk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      vs_d_q    <= 1'b1;
      pix_cnt_q <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      fdone_q   <= 1'b0;
      done_q    <= 1'b0;
      short_q   <= 1'b0;
      fcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      vs_d_q    <= CAM_vsync;
      pix_cnt_q <= pix_cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      busy_q    <= busy_d;
      fdone_q   <= fdone_d;
      done_q    <= done_d;
      short_q   <= short_d;
      fcnt_q    <= fcnt_d;
    end
  end

  assign DP_RAM_addr_out = addr_q;
  assign DP_RAM_data_out = data_q;
  assign DP_RAM_regW_out = wr_q;
  assign busy            = busy_q;
  assign frame_done      = fdone_q;
  assign done            = done_q;
  assign short_frame     = short_q;
  assign frame_cnt       = fcnt_q;

endmodule
